crossbar_arbiter: RTL and testbench
===================================

CROSSBAR_ARBITER -- requirements
Module: crossbar_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 8'd255, number of BUSY cycles without slave ack before forced release; 0 disables timeout.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_from_master_if  input  4  per-master request for this slave port; bit i belongs to master i.
REQ-005 addr_from_master_if  input  128  four packed 32-bit addresses; master i at [32*i+31:32*i].
REQ-006 wdata_from_master_if  input  128  four packed 32-bit write data words, same packing.
REQ-007 cmd_from_master_if  input  4  per-master command; 1 = write, 0 = read.
REQ-008 ack_from_slave  input  1  slave transaction-complete strobe.
REQ-009 rdata_from_slave  input  32  slave read data, valid with ack_from_slave.
REQ-010 connect_approved  output  4  one-hot grant to master i's interface; at most one bit high.
REQ-011 ack_to_master_if  output  4  per-master ack; only the granted bit may be high.
REQ-012 rdata_to_master_if  output  32  shared read-data bus to all master interfaces.
REQ-013 req_to_slave, addr_to_slave[31:0], wdata_to_slave[31:0], cmd_to_slave  output  muxed request from granted master.
REQ-014 timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-015 State machine SHALL have two states: IDLE, BUSY; a 2-bit round-robin pointer ptr and a 2-bit registered grant index g.
REQ-016 IDLE, any req bit set: g SHALL take the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); next state BUSY.
REQ-017 IDLE, no req: state, ptr, g unchanged.
REQ-018 Grant latency SHALL be exactly one cycle: request sampled at edge N, connect_approved[g] high from cycle N+1.
REQ-019 In IDLE all outputs except timeout_err SHALL be zero; timeout_err SHALL also be zero unless REQ-025 applies.
REQ-020 In BUSY: connect_approved = one-hot(g); req_to_slave = req_from_master_if[g]; addr/wdata/cmd_to_slave = master g's fields.
REQ-021 In BUSY ack_to_master_if[g] = ack_from_slave, combinational; other bits 0.
REQ-022 rdata_to_master_if SHALL equal rdata_from_slave when BUSY and ack_from_slave, else 32'h0.
REQ-023 Completion: BUSY with ack_from_slave high SHALL go IDLE next edge, ptr = g+1 mod 4 (wrap 3 -> 0).
REQ-024 Abandon: BUSY with req_from_master_if[g] low and ack low SHALL go IDLE, ptr = g+1 mod 4, no error.
REQ-025 Timeout: 8-bit counter SHALL clear on entry to BUSY, increment each BUSY cycle without ack; reaching TIMEOUT (TIMEOUT != 0) SHALL go IDLE, ptr = g+1, and pulse timeout_err in the first IDLE cycle.
REQ-026 Simultaneous ack and timeout or ack and request drop: ack wins; completion per REQ-023, no timeout_err.
REQ-027 ack_from_slave in IDLE SHALL be ignored and not forwarded.
REQ-028 Requests from non-granted masters during BUSY SHALL not affect outputs; they compete at the next IDLE.
REQ-029 Minimum gap between consecutive grants SHALL be one IDLE cycle (no back-to-back BUSY).

Reset
REQ-030 rst high at an edge SHALL set state IDLE, ptr 0, g 0, counter 0, timeout_err 0; all outputs zero from the following cycle.
REQ-031 rst asserted mid-BUSY SHALL drop the grant without asserting ack_to_master_if or timeout_err; the pending transaction is lost.
REQ-032 rst has priority over all other events in the same cycle.

Verification
REQ-033 After reset, req=4'b0001, addr0=32'h1000_0000 -> cycle+1 connect_approved=4'b0001, addr_to_slave=32'h1000_0000, req_to_slave=1.
REQ-034 req=4'b1111 held, slave acks 2 cycles after each grant -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-035 BUSY on master 2, ack_from_slave=1, rdata_from_slave=32'hDEAD_BEEF -> same cycle ack_to_master_if=4'b0100, rdata_to_master_if=32'hDEAD_BEEF; next cycle IDLE, ptr=3.
REQ-036 TIMEOUT=4, grant to master 1, no ack -> release after 4 BUSY cycles, timeout_err pulses 1 cycle, ptr=2; ack on cycle 4 instead -> no timeout_err.
REQ-037 rst asserted during BUSY on master 3 -> next cycle connect_approved=0, ptr=0; req=4'b1000 re-granted one cycle after rst drops.

Source files
------------

// File: rtl/crossbar_arbiter.sv
// rtl/crossbar_arbiter.sv - round-robin arbiter for one crossbar slave port
//
// Purpose: grants one of four master interfaces access to a single slave port.
//   Grants are round-robin, starting from a rotating pointer. A grant ends when
//   the slave acks, when the granted master drops its request, or when the
//   slave stays silent for TIMEOUT busy cycles. TIMEOUT = 0 disables the timeout.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_from_master_if[3:0]   per-master request
//   addr_from_master_if       4 x 32-bit addresses, master i at [32*i +: 32]
//   wdata_from_master_if      4 x 32-bit write data, same packing
//   cmd_from_master_if[3:0]   per-master command, 1 = write, 0 = read
//   ack_from_slave            slave transaction-complete strobe
//   rdata_from_slave[31:0]    slave read data, valid with ack_from_slave
//   connect_approved[3:0]     one-hot grant
//   ack_to_master_if[3:0]     ack routed to the granted master only
//   rdata_to_master_if[31:0]  shared read-data bus, zero unless acked
//   req/addr/wdata/cmd_to_slave  request fields of the granted master
//   timeout_err               one-cycle pulse after a forced release
module crossbar_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_from_master_if,
  input  logic [127:0] addr_from_master_if,
  input  logic [127:0] wdata_from_master_if,
  input  logic [3:0]   cmd_from_master_if,
  input  logic         ack_from_slave,
  input  logic [31:0]  rdata_from_slave,
  output logic [3:0]   connect_approved,
  output logic [3:0]   ack_to_master_if,
  output logic [31:0]  rdata_to_master_if,
  output logic         req_to_slave,
  output logic [31:0]  addr_to_slave,
  output logic [31:0]  wdata_to_slave,
  output logic         cmd_to_slave,
  output logic         timeout_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state, next_state;
  logic [1:0] ptr, next_ptr;
  logic [1:0] g, next_g;
  logic [7:0] cnt, next_cnt;
  logic       terr, next_terr;
  logic [1:0] pick;
  logic [1:0] idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      g     <= 2'd0;
      cnt   <= 8'd0;
      terr  <= 1'b0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
      g     <= next_g;
      cnt   <= next_cnt;
      terr  <= next_terr;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    next_g     = g;
    next_cnt   = cnt;
    next_terr  = 1'b0;
    pick       = ptr;
    idx        = ptr;

    // Walk from the farthest candidate back to ptr so the closest set bit wins.
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + i[1:0];
      if (req_from_master_if[idx]) pick = idx;
    end

    case (state)
      IDLE: begin
        if (|req_from_master_if) begin
          next_state = BUSY;
          next_g     = pick;
          next_cnt   = 8'd0;
        end
      end
      BUSY: begin
        // Ack has priority over both abandon and timeout.
        if (ack_from_slave) begin
          next_state = IDLE;
          next_ptr   = g + 2'd1;
        end else if (!req_from_master_if[g]) begin
          next_state = IDLE;
          next_ptr   = g + 2'd1;
        end else if ((TIMEOUT != 8'd0) && (cnt + 8'd1 == TIMEOUT)) begin
          next_state = IDLE;
          next_ptr   = g + 2'd1;
          next_terr  = 1'b1;
        end else begin
          next_cnt = cnt + 8'd1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    connect_approved   = 4'b0000;
    ack_to_master_if   = 4'b0000;
    rdata_to_master_if = 32'h0;
    req_to_slave       = 1'b0;
    addr_to_slave      = 32'h0;
    wdata_to_slave     = 32'h0;
    cmd_to_slave       = 1'b0;
    timeout_err        = terr;
    if (state == BUSY) begin
      connect_approved    = 4'b0001 << g;
      req_to_slave        = req_from_master_if[g];
      addr_to_slave       = addr_from_master_if[{g, 5'd0} +: 32];
      wdata_to_slave      = wdata_from_master_if[{g, 5'd0} +: 32];
      cmd_to_slave        = cmd_from_master_if[g];
      ack_to_master_if[g] = ack_from_slave;
      if (ack_from_slave) rdata_to_master_if = rdata_from_slave;
    end
  end

endmodule

// File: tb/tb_crossbar_arbiter.sv
// tb/tb_crossbar_arbiter.sv - directed self-checking bench for crossbar_arbiter
module tb_crossbar_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] addr;
  logic [127:0] wdata;
  logic [3:0]   cmd;
  logic         ack;
  logic [31:0]  rdata;
  logic [3:0]   connect_approved;
  logic [3:0]   ack_to_master_if;
  logic [31:0]  rdata_to_master_if;
  logic         req_to_slave;
  logic [31:0]  addr_to_slave;
  logic [31:0]  wdata_to_slave;
  logic         cmd_to_slave;
  logic         timeout_err;

  int tests = 0;
  int fails = 0;

  crossbar_arbiter #(.TIMEOUT(8'd4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_from_master_if   (req),
    .addr_from_master_if  (addr),
    .wdata_from_master_if (wdata),
    .cmd_from_master_if   (cmd),
    .ack_from_slave       (ack),
    .rdata_from_slave     (rdata),
    .connect_approved     (connect_approved),
    .ack_to_master_if     (ack_to_master_if),
    .rdata_to_master_if   (rdata_to_master_if),
    .req_to_slave         (req_to_slave),
    .addr_to_slave        (addr_to_slave),
    .wdata_to_slave       (wdata_to_slave),
    .cmd_to_slave         (cmd_to_slave),
    .timeout_err          (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    req   = 4'b0000;
    ack   = 1'b0;
    rdata = 32'h0;
    cmd   = 4'b0101;
    addr  = {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
    wdata = {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};

    // Reset state
    do_reset();
    #1;
    check("rst_connect", {28'h0, connect_approved}, 32'h0);
    check("rst_req_slave", {31'h0, req_to_slave}, 32'h0);
    check("rst_addr", addr_to_slave, 32'h0);
    check("rst_terr", {31'h0, timeout_err}, 32'h0);
    check("rst_ptr", {30'h0, dut.ptr}, 32'h0);

    // Single request from master 0, granted one cycle later
    req = 4'b0001;
    #1;
    check("m0_idle_connect", {28'h0, connect_approved}, 32'h0);
    tick();
    check("m0_connect", {28'h0, connect_approved}, 32'h1);
    check("m0_addr", addr_to_slave, 32'h1000_0000);
    check("m0_req_slave", {31'h0, req_to_slave}, 32'h1);
    check("m0_wdata", wdata_to_slave, 32'hA0A0_A0A0);
    check("m0_cmd", {31'h0, cmd_to_slave}, 32'h1);
    ack = 1'b1;
    rdata = 32'h0000_0055;
    #1;
    check("m0_ack", {28'h0, ack_to_master_if}, 32'h1);
    check("m0_rdata", rdata_to_master_if, 32'h0000_0055);
    tick();
    ack = 1'b0;
    req = 4'b0000;
    #1;
    check("m0_done_connect", {28'h0, connect_approved}, 32'h0);
    check("m0_done_ptr", {30'h0, dut.ptr}, 32'h1);
    check("m0_done_terr", {31'h0, timeout_err}, 32'h0);

    // All four requesting: order 0,1,2,3,0 with an idle gap between grants
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rr%0d_grant", k), {28'h0, connect_approved}, 32'h1 << (k % 4));
      tick();
      tick();
      ack = 1'b1;
      rdata = 32'h100 + k;
      #1;
      check($sformatf("rr%0d_ack", k), {28'h0, ack_to_master_if}, 32'h1 << (k % 4));
      tick();
      ack = 1'b0;
      #1;
      check($sformatf("rr%0d_gap", k), {28'h0, connect_approved}, 32'h0);
    end
    req = 4'b0000;

    // Master 2 busy with others requesting; ack carries read data
    req = 4'b0100;
    tick();
    check("m2_connect", {28'h0, connect_approved}, 32'h4);
    req = 4'b1101;
    #1;
    check("m2_others_connect", {28'h0, connect_approved}, 32'h4);
    check("m2_addr", addr_to_slave, 32'h3000_0000);
    check("m2_wdata", wdata_to_slave, 32'hC2C2_C2C2);
    ack = 1'b1;
    rdata = 32'hDEAD_BEEF;
    #1;
    check("m2_ack", {28'h0, ack_to_master_if}, 32'h4);
    check("m2_rdata", rdata_to_master_if, 32'hDEAD_BEEF);
    tick();
    ack = 1'b0;
    #1;
    check("m2_done_connect", {28'h0, connect_approved}, 32'h0);
    check("m2_done_ptr", {30'h0, dut.ptr}, 32'h3);

    // Pointer at 3 picks master 3 first; then master 3 abandons
    tick();
    check("m3_connect", {28'h0, connect_approved}, 32'h8);
    req = 4'b0101;
    tick();
    #1;
    check("abandon_connect", {28'h0, connect_approved}, 32'h0);
    check("abandon_ptr", {30'h0, dut.ptr}, 32'h0);
    check("abandon_terr", {31'h0, timeout_err}, 32'h0);
    req = 4'b0000;

    // Ack in IDLE is not forwarded
    ack = 1'b1;
    rdata = 32'h0000_0123;
    #1;
    check("idle_ack", {28'h0, ack_to_master_if}, 32'h0);
    check("idle_rdata", rdata_to_master_if, 32'h0);
    tick();
    ack = 1'b0;
    #1;
    check("idle_ack_state", {28'h0, connect_approved}, 32'h0);

    // Timeout: master 1 held for 4 busy cycles without ack
    req = 4'b0010;
    tick();
    check("to_c1", {28'h0, connect_approved}, 32'h2);
    tick();
    tick();
    tick();
    check("to_c4", {28'h0, connect_approved}, 32'h2);
    check("to_c4_terr", {31'h0, timeout_err}, 32'h0);
    tick();
    check("to_rel_connect", {28'h0, connect_approved}, 32'h0);
    check("to_rel_terr", {31'h0, timeout_err}, 32'h1);
    check("to_rel_ptr", {30'h0, dut.ptr}, 32'h2);
    tick();
    check("to_regrant", {28'h0, connect_approved}, 32'h2);
    check("to_pulse_end", {31'h0, timeout_err}, 32'h0);
    // Ack in the 4th busy cycle wins over the timeout
    tick();
    tick();
    tick();
    ack = 1'b1;
    #1;
    check("to_ack_c4", {28'h0, ack_to_master_if}, 32'h2);
    tick();
    ack = 1'b0;
    req = 4'b0000;
    #1;
    check("to_ack_terr", {31'h0, timeout_err}, 32'h0);
    check("to_ack_ptr", {30'h0, dut.ptr}, 32'h2);
    check("to_ack_connect", {28'h0, connect_approved}, 32'h0);

    // Reset mid-BUSY on master 3, then re-grant after release
    req = 4'b1000;
    tick();
    check("rb_connect", {28'h0, connect_approved}, 32'h8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rb_connect_drop", {28'h0, connect_approved}, 32'h0);
    check("rb_ptr", {30'h0, dut.ptr}, 32'h0);
    check("rb_ack", {28'h0, ack_to_master_if}, 32'h0);
    check("rb_terr", {31'h0, timeout_err}, 32'h0);
    tick();
    check("rb_regrant", {28'h0, connect_approved}, 32'h8);
    check("rb_addr", addr_to_slave, 32'h4000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
